// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte-wide register file.
// Bus side uses an auto-incrementing pointer; host side reads/writes directly.
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR  = 7'h1E,
   parameter int         NREG_LOG2 = 3
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 sda_oe,
   input  logic                 host_we,
   input  logic [NREG_LOG2-1:0] host_addr,
   input  logic [7:0]           host_wdata,
   output logic [7:0]           host_rdata,
   output logic                 i2c_wr_stb,
   output logic [NREG_LOG2-1:0] i2c_wr_addr,
   output logic [7:0]           i2c_wr_data,
   output logic                 busy,
   output logic [7:0]           State
);

   localparam int NREG = 1 << NREG_LOG2;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ADDR      = 4'd1,
      S_ADDR_ACK  = 4'd2,
      S_PTR       = 4'd3,
      S_PTR_ACK   = 4'd4,
      S_WDATA     = 4'd5,
      S_WDATA_ACK = 4'd6,
      S_RDATA     = 4'd7,
      S_RACK      = 4'd8,
      S_WAIT_STOP = 4'd9
   } state_t;

   state_t                r_state, w_state_nx;
   logic [1:0]            r_scl_q, r_sda_q;
   logic                  r_scl_d, r_sda_d;
   logic [3:0]            r_bitcnt, w_bitcnt_nx;
   logic [7:0]            r_shift, w_shift_nx;
   logic [NREG_LOG2-1:0]  r_ptr, w_ptr_nx, w_ptr_inc;
   logic                  r_rw, w_rw_nx;
   logic                  r_oe, w_oe_nx;
   logic                  r_busy, w_busy_nx;
   logic                  w_commit;
   logic                  r_wr_stb;
   logic [NREG_LOG2-1:0]  r_wr_addr;
   logic [7:0]            r_wr_data;
   logic [7:0]            r_regs [NREG];
   logic                  w_scl, w_sda;
   logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0]            w_rd_cur, w_rd_nxt;

   assign w_scl      = r_scl_q[1];
   assign w_sda      = r_sda_q[1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_ptr_inc  = r_ptr + NREG_LOG2'(1);
   assign w_rd_cur   = r_regs[r_ptr];
   assign w_rd_nxt   = r_regs[w_ptr_inc];

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_q <= 2'b11;
         r_sda_q <= 2'b11;
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_q <= {r_scl_q[0], scl_in};
         r_sda_q <= {r_sda_q[0], sda_in};
         r_scl_d <= w_scl;
         r_sda_d <= w_sda;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx  = r_state;
      w_bitcnt_nx = r_bitcnt;
      w_shift_nx  = r_shift;
      w_ptr_nx    = r_ptr;
      w_rw_nx     = r_rw;
      w_oe_nx     = r_oe;
      w_busy_nx   = r_busy;
      w_commit    = 1'b0;
      if (w_stop) begin
         w_state_nx = S_IDLE;
         w_oe_nx    = 1'b0;
         w_busy_nx  = 1'b0;
      end else if (w_start) begin
         w_state_nx  = S_ADDR;
         w_bitcnt_nx = 4'd0;
         w_oe_nx     = 1'b0;
      end else begin
         unique case (r_state)
            S_ADDR, S_PTR, S_WDATA: begin
               if (w_scl_rise && r_bitcnt != 4'd8) begin
                  w_shift_nx  = {r_shift[6:0], w_sda};
                  w_bitcnt_nx = r_bitcnt + 4'd1;
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  w_oe_nx = 1'b1;
                  if (r_state == S_ADDR) begin
                     if (r_shift[7:1] == DEV_ADDR) begin
                        w_state_nx = S_ADDR_ACK;
                        w_busy_nx  = 1'b1;
                        w_rw_nx    = r_shift[0];
                     end else begin
                        w_state_nx = S_WAIT_STOP;
                        w_busy_nx  = 1'b0;
                        w_oe_nx    = 1'b0;
                     end
                  end else if (r_state == S_PTR) begin
                     w_ptr_nx   = r_shift[NREG_LOG2-1:0];
                     w_state_nx = S_PTR_ACK;
                  end else begin
                     w_commit   = 1'b1;
                     w_ptr_nx   = w_ptr_inc;
                     w_state_nx = S_WDATA_ACK;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_oe_nx     = 1'b0;
                  w_bitcnt_nx = 4'd0;
                  w_state_nx  = S_PTR;
                  if (r_rw) begin
                     // first read bit goes out on the same edge that ends the ACK
                     w_oe_nx     = ~w_rd_cur[7];
                     w_shift_nx  = {w_rd_cur[6:0], 1'b0};
                     w_bitcnt_nx = 4'd1;
                     w_state_nx  = S_RDATA;
                  end
               end
            end
            S_PTR_ACK, S_WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_oe_nx     = 1'b0;
                  w_bitcnt_nx = 4'd0;
                  w_state_nx  = S_WDATA;
               end
            end
            S_RDATA: begin
               if (w_scl_fall) begin
                  if (r_bitcnt == 4'd8) begin
                     w_oe_nx    = 1'b0;
                     w_state_nx = S_RACK;
                  end else begin
                     w_oe_nx     = ~r_shift[7];
                     w_shift_nx  = {r_shift[6:0], 1'b0};
                     w_bitcnt_nx = r_bitcnt + 4'd1;
                  end
               end
            end
            S_RACK: begin
               if (w_scl_rise) begin
                  if (!w_sda) begin
                     w_ptr_nx    = w_ptr_inc;
                     w_shift_nx  = w_rd_nxt;
                     w_bitcnt_nx = 4'd0;
                     w_state_nx  = S_RDATA;
                  end else begin
                     w_state_nx = S_WAIT_STOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitcnt  <= 4'd0;
         r_shift   <= 8'd0;
         r_ptr     <= '0;
         r_rw      <= 1'b0;
         r_oe      <= 1'b0;
         r_busy    <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= 8'd0;
      end else begin
         r_bitcnt <= w_bitcnt_nx;
         r_shift  <= w_shift_nx;
         r_ptr    <= w_ptr_nx;
         r_rw     <= w_rw_nx;
         r_oe     <= w_oe_nx;
         r_busy   <= w_busy_nx;
         r_wr_stb <= w_commit;
         if (w_commit) begin
            r_wr_addr <= r_ptr;
            r_wr_data <= r_shift;
         end
      end
   end

   // bus commit is applied last so it wins a same-register collision
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= 8'd0;
      end else begin
         if (host_we)  r_regs[host_addr] <= host_wdata;
         if (w_commit) r_regs[r_ptr]     <= r_shift;
      end
   end

   assign sda_oe      = r_oe;
   assign busy        = r_busy;
   assign host_rdata  = r_regs[host_addr];
   assign i2c_wr_stb  = r_wr_stb;
   assign i2c_wr_addr = r_wr_addr;
   assign i2c_wr_data = r_wr_data;
   assign State       = {4'b0000, r_state};

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs.
// Bit-bangs an I2C master and checks ACKs, read data, strobes and registers.
`timescale 1ns/1ps
module tb_i2c_target_regs;

   localparam int H = 5;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic       scl_in;
   logic       sda_drv;
   logic       sda_in;
   logic       sda_oe;
   logic       host_we;
   logic [2:0] host_addr;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       i2c_wr_stb;
   logic [2:0] i2c_wr_addr;
   logic [7:0] i2c_wr_data;
   logic       busy;
   logic [7:0] State;

   int n_chk  = 0;
   int n_fail = 0;
   int stb_cnt = 0;
   logic [10:0] stb_log [$];

   always #5 sys_clk = ~sys_clk;

   assign sda_in = sda_drv & ~sda_oe;

   i2c_target_regs dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .scl_in      (scl_in),
      .sda_in      (sda_in),
      .sda_oe      (sda_oe),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .i2c_wr_stb  (i2c_wr_stb),
      .i2c_wr_addr (i2c_wr_addr),
      .i2c_wr_data (i2c_wr_data),
      .busy        (busy),
      .State       (State)
   );

   always @(negedge sys_clk) begin
      if (i2c_wr_stb) begin
         stb_cnt++;
         stb_log.push_back({i2c_wr_addr, i2c_wr_data});
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send_bit(input logic b, input logic hw, output logic smp);
      sda_drv = b;
      wait_n(H);
      scl_in = 1'b1;
      wait_n(H);
      smp = sda_in;
      wait_n(H);
      scl_in = 1'b0;
      if (hw) begin
         @(posedge sys_clk);
         @(posedge sys_clk);
         @(negedge sys_clk);
         host_we = 1'b1;
         @(negedge sys_clk);
         host_we = 1'b0;
         check("collide_stb", 32'(i2c_wr_stb), 32'd1);
         wait_n(H - 2);
      end else begin
         wait_n(H);
      end
   endtask

   task automatic start_c();
      sda_drv = 1'b1;
      wait_n(H);
      scl_in = 1'b1;
      wait_n(H);
      sda_drv = 1'b0;
      wait_n(H);
      scl_in = 1'b0;
      wait_n(H);
   endtask

   task automatic stop_c();
      sda_drv = 1'b0;
      wait_n(H);
      scl_in = 1'b1;
      wait_n(H);
      sda_drv = 1'b1;
      wait_n(H);
   endtask

   task automatic wr_byte(input logic [7:0] d, input logic hw, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(d[i], hw && (i == 0), s);
      send_bit(1'b1, 1'b0, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, 1'b0, s);
         d[i] = s;
      end
      send_bit(mack, 1'b0, s);
   endtask

   task automatic host_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge sys_clk);
      host_addr  = a;
      host_wdata = d;
      host_we    = 1'b1;
      @(negedge sys_clk);
      host_we    = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a,
                            input logic [7:0] exp);
      @(negedge sys_clk);
      host_addr = a;
      #1;
      check(tag, 32'(host_rdata), 32'(exp));
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      scl_in     = 1'b1;
      sda_drv    = 1'b1;
      host_we    = 1'b0;
      host_addr  = 3'd0;
      host_wdata = 8'd0;
      rst_n      = 1'b0;
      wait_n(3);
      check("rst_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(State), 32'd0);
      check("rst_stb", 32'(i2c_wr_stb), 32'd0);
      check_reg("rst_reg5", 3'd5, 8'h00);
      rst_n = 1'b1;
      wait_n(3);

      // plain write: ptr 2, two data bytes
      start_c();
      wr_byte(8'h3C, 1'b0, ack);
      check("w_addr_ack", 32'(ack), 32'd0);
      check("w_busy", 32'(busy), 32'd1);
      wr_byte(8'h02, 1'b0, ack);
      check("w_ptr_ack", 32'(ack), 32'd0);
      wr_byte(8'hA5, 1'b0, ack);
      check("w_d0_ack", 32'(ack), 32'd0);
      wr_byte(8'h5A, 1'b0, ack);
      check("w_d1_ack", 32'(ack), 32'd0);
      stop_c();
      wait_n(2);
      check("w_busy_off", 32'(busy), 32'd0);
      check_reg("w_reg2", 3'd2, 8'hA5);
      check_reg("w_reg3", 3'd3, 8'h5A);
      check("w_stb_cnt", 32'(stb_cnt), 32'd2);
      check("w_stb0", 32'(stb_log.size() > 0 ? stb_log[0] : 11'h0), 32'h2A5);
      check("w_stb1", 32'(stb_log.size() > 1 ? stb_log[1] : 11'h0), 32'h35A);

      // read with wrap, repeated START, snapshot of in-flight byte
      host_write(3'd7, 8'h11);
      host_write(3'd0, 8'h22);
      start_c();
      wr_byte(8'h3C, 1'b0, ack);
      wr_byte(8'h07, 1'b0, ack);
      check("r_ptr_ack", 32'(ack), 32'd0);
      start_c();
      wr_byte(8'h3D, 1'b0, ack);
      check("r_addr_ack", 32'(ack), 32'd0);
      host_write(3'd7, 8'h44);
      rd_byte(1'b0, d);
      check("r_byte0", 32'(d), 32'h11);
      rd_byte(1'b1, d);
      check("r_byte1_wrap", 32'(d), 32'h22);
      wait_n(2);
      check("r_wait_stop", 32'(State), 32'd9);
      stop_c();
      wait_n(2);
      check("r_idle", 32'(State), 32'd0);
      check("r_busy_off", 32'(busy), 32'd0);
      check_reg("r_reg7_host", 3'd7, 8'h44);
      check("r_no_stb", 32'(stb_cnt), 32'd2);

      // wrong address is ignored, then re-addressed
      start_c();
      wr_byte(8'h3A, 1'b0, ack);
      check("m_nack", 32'(ack), 32'd1);
      wait_n(2);
      check("m_busy", 32'(busy), 32'd0);
      check("m_wait_stop", 32'(State), 32'd9);
      check_reg("m_reg2", 3'd2, 8'hA5);
      start_c();
      wr_byte(8'h3C, 1'b0, ack);
      check("m_readdr_ack", 32'(ack), 32'd0);
      stop_c();

      // host/bus collisions: same register, then different registers
      start_c();
      wr_byte(8'h3C, 1'b0, ack);
      wr_byte(8'h04, 1'b0, ack);
      host_addr  = 3'd4;
      host_wdata = 8'h99;
      wr_byte(8'h77, 1'b1, ack);
      host_addr  = 3'd6;
      host_wdata = 8'h66;
      wr_byte(8'h88, 1'b1, ack);
      stop_c();
      check_reg("c_reg4", 3'd4, 8'h77);
      check_reg("c_reg5", 3'd5, 8'h88);
      check_reg("c_reg6", 3'd6, 8'h66);
      check("c_stb_cnt", 32'(stb_cnt), 32'd4);

      // read continues from persisted ptr, then reset mid-byte
      start_c();
      wr_byte(8'h3D, 1'b0, ack);
      rd_byte(1'b0, d);
      check("p_byte_reg6", 32'(d), 32'h66);
      check("p_oe_driving", 32'(sda_oe), 32'd1);
      check("p_rdata_state", 32'(State), 32'd7);
      @(negedge sys_clk);
      rst_n = 1'b0;
      #1;
      check("x_oe_async", 32'(sda_oe), 32'd0);
      check("x_busy", 32'(busy), 32'd0);
      check("x_state", 32'(State), 32'd0);
      for (int i = 0; i < 8; i++) check_reg($sformatf("x_reg%0d", i), 3'(i), 8'h00);
      wait_n(2);
      rst_n = 1'b1;
      wait_n(3);
      stop_c();
      start_c();
      wr_byte(8'h3D, 1'b0, ack);
      check("x_addr_ack", 32'(ack), 32'd0);
      rd_byte(1'b1, d);
      check("x_read_zero", 32'(d), 32'h00);
      stop_c();
      wait_n(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter: DEV_ADDR, default 7'h1E, 7-bit I2C address this target answers to.
REQ-002 Parameter: NREG_LOG2, default 3, log2 of the register count (8 registers, 8 bits each).
REQ-003 Clock and reset: one clock, sys_clk; reset is asynchronous and active-low, rst_n.
REQ-004 Port: sys_clk  input  1  system clock; must be at least 16x the SCL frequency.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: scl_in  input  1  raw SCL pin level.
REQ-007 Port: sda_in  input  1  raw SDA pin level.
REQ-008 Port: sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release SDA.
REQ-009 Port: host_we  input  1  host register-write strobe.
REQ-010 Port: host_addr  input  NREG_LOG2  host register index.
REQ-011 Port: host_wdata  input  8  host write data.
REQ-012 Port: host_rdata  output  8  combinational register[host_addr].
REQ-013 Port: i2c_wr_stb  output  1  one-cycle pulse when an I2C data byte is committed.
REQ-014 Port: i2c_wr_addr  output  NREG_LOG2  register index of the committed byte.
REQ-015 Port: i2c_wr_data  output  8  value of the committed byte.
REQ-016 Port: busy  output  1  high from START to STOP while addressed.
REQ-017 Port: State  output  8  current FSM state encoding, for ILA probing.

Function
REQ-018 scl_in and sda_in SHALL pass through 2-flop synchronizers; edges are detected on the synchronized copies, so the response lags the pin by 3 sys_clk.
REQ-019 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are detected in every state, and repeated START is legal at any time.
REQ-020 On START: clear the bit counter, release SDA, and enter ADDR.
REQ-021 On STOP: enter IDLE, release SDA, and deassert busy.
REQ-022 Bit sampling: capture data on the SCL rising edge, MSB first; change driven SDA only on the SCL falling edge.
REQ-023 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-024 ADDR, after 8 bits: on an address match, go to ADDR_ACK and set busy; on a mismatch, go to WAIT_STOP with SDA released.
REQ-025 ACK phases: assert sda_oe at the SCL falling edge ending bit 8; release it at the next SCL falling edge.
REQ-026 After ADDR_ACK: R/W=0 goes to PTR; R/W=1 goes to RDATA, loading the shift register with reg[ptr].
REQ-027 PTR: the low NREG_LOG2 bits of the received byte load ptr and the upper bits are ignored; then PTR_ACK, then WDATA.
REQ-028 WDATA, after 8 bits: write reg[ptr], pulse i2c_wr_stb for exactly 1 cycle with the address and data, increment ptr, then WDATA_ACK, then WDATA.
REQ-029 RDATA: drive sda_oe = ~shift[7] on each SCL falling edge; after the 8th bit, release SDA and enter RACK.
REQ-030 RACK: sample SDA on SCL rising. ACK (0): increment ptr, load the next byte, go to RDATA. NACK (1): go to WAIT_STOP.
REQ-031 ptr increments modulo 2^NREG_LOG2 (7 wraps to 0).
REQ-032 A read byte SHALL be snapshotted at load time; host writes to that register afterwards do not alter the byte in flight.
REQ-033 A host_we and an I2C commit to the same register in the same cycle: the I2C write wins; to different registers, both take effect.
REQ-034 ptr persists across transactions, so a read without a pointer phase continues from the last ptr.

Reset
REQ-035 While rst_n is low: all registers and ptr = 0, state = IDLE, sda_oe = 0, busy = 0, i2c_wr_stb = 0, and synchronizers preset to 1.
REQ-036 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after release, the block ignores the bus until the next START.

Verification
REQ-037 Write 0x3C(W), ptr 0x02, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg2=0xA5, reg3=0x5A; two i2c_wr_stb pulses (addr 2/A5, addr 3/5A).
REQ-038 Host preloads reg7=0x11, reg0=0x22; bus writes 0x3C, ptr 0x07, repeated START, 0x3D, master ACKs then NACKs -> reads 0x11, 0x22 (wrap); then WAIT_STOP.
REQ-039 Address 0x3A(W) -> no ACK (SDA stays high at bit 9), busy stays 0, no register changes; next START with 0x3C is ACKed.
REQ-040 Host writes reg4=0x99 while the bus commits reg4=0x77 in the same cycle -> reg4=0x77.
REQ-041 rst_n pulsed low during RDATA while sda_oe=1 -> sda_oe=0 within the same cycle; all registers read 0; the following 0x3D read returns 0x00.
